rptr_empty_fwft: RTL and testbench
==================================

Name: rptr_empty_fwft

Overview:
- Read-side pointer, empty and almost-empty logic for the dual-clock FIFO in the AXI clock-crossing path.
- Counterpart of the write-side pointer/full block.
- Keeps a binary and a Gray read pointer in the rclk domain and compares the next Gray pointer against the synchronised write pointer to derive empty and almost-empty.
- Adds a first-word-fall-through output register with a valid/ready handshake and a registered occupancy count.

Parameters:
ADDRSIZE  4   FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits
DATASIZE  32  width of FIFO data word

Ports:
rclk       input   1            read-domain clock
rrst_n     input   1            asynchronous active-low reset
rq2_wptr   input   ADDRSIZE+1   write Gray pointer, already 2-FF synchronised into rclk
rmem_data  input   DATASIZE     RAM read data at raddr (combinational read port)
rready     input   1            consumer accepts rdata this cycle
raddr      output  ADDRSIZE     RAM read address, = rbin[ADDRSIZE-1:0]
rptr       output  ADDRSIZE+1   registered Gray read pointer, sent to write domain
rempty     output  1            registered: RAM holds no unread entry
arempty    output  1            registered: RAM holds at most one unread entry
rvalid     output  1            output register holds a valid word
rdata      output  DATASIZE     output register data
rlevel     output  ADDRSIZE+1   registered count of unread RAM entries (output register excluded)

Behaviour:
- One clock domain (rclk). rrst_n is asynchronous and active-low; all state is reset when it is low.
- Reset values:
  - rbin = 0, rptr = 0 (so raddr = 0)
  - rempty = 1, arempty = 1
  - rvalid = 0, rdata = 0, rlevel = 0
- Internal pop: rd_en = ~rempty & (~rvalid | rready).
  - rd_en is the only thing that advances the pointer.
  - rready while rvalid = 0 is ignored.
- Pointer arithmetic:
  - rbinnext = rbin + rd_en, modulo 2^(ADDRSIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
  - rgraynextp1 = Gray of (rbinnext + 1), modulo 2^(ADDRSIZE+1).
  - Each rclk edge: rbin <= rbinnext, rptr <= rgraynext.
- Flags, registered each edge:
  - rempty <= (rgraynext == rq2_wptr).
  - arempty <= (rgraynext == rq2_wptr) | (rgraynextp1 == rq2_wptr).
- Level:
  - rlevel <= gray2bin(rq2_wptr) - rbinnext, modulo 2^(ADDRSIZE+1).
  - Range 0 .. 2^ADDRSIZE; full RAM gives 2^ADDRSIZE.
- Output register:
  - If rd_en: rdata <= rmem_data (word at the current raddr), rvalid <= 1.
  - Else if rready & rvalid: rvalid <= 0, rdata holds its value.
  - Else: rvalid and rdata hold.
- Handshake:
  - A word transfers on an edge where rvalid & rready.
  - A simultaneous transfer and pop refills the register in the same edge: back-to-back throughput of 1 word per cycle.
  - Once rvalid = 1, rdata is stable until that word transfers.
- Latency:
  - The first write shows up in rq2_wptr; rempty falls on the next edge.
  - rd_en then asserts in the following cycle, and rvalid rises one edge after that.
- Wrap-around:
  - The pointer MSB toggles each pass through the RAM.
  - Empty needs an exact match of all ADDRSIZE+1 Gray bits.
  - 2^ADDRSIZE unread entries is not empty; rlevel = 2^ADDRSIZE.
- Empty boundary:
  - When the last RAM entry is popped, rempty = 1 on that same edge.
  - No pop happens while rempty = 1, even if rq2_wptr changes in that cycle; the pop is taken next cycle after the flag updates.
- Reset mid-operation:
  - An unread output word is discarded: rvalid = 0 immediately.
  - Pointers return to 0; the write side is reset by the same system reset.
- rptr changes by at most one Gray bit per edge.

Test Plan:
- Reset with rq2_wptr = 0 -> rempty = 1, arempty = 1, rvalid = 0, rptr = 0, rlevel = 0; rready = 1 for 10 cycles leaves raddr = 0.
- rq2_wptr stepped 0 -> 1 (Gray), rmem_data = 0xA5A5A5A5, rready = 0:
  - Next edge: rempty = 0, arempty = 1, rlevel = 1.
  - Following edge: rvalid = 1, rdata = 0xA5A5A5A5, rptr = 1, rempty = 1, rlevel = 0.
  - Hold rready = 0 for 5 cycles -> rvalid and rdata stable, raddr = 1.
- ADDRSIZE = 4, rq2_wptr = Gray(16) = 0x18, rready = 1, rmem_data = raddr:
  - Initial rlevel = 16, rempty = 0, arempty = 0.
  - 16 consecutive transfers: rdata = 0..15, one per cycle.
  - arempty rises once rlevel = 1; rempty = 1 after the 16th pop; rptr = 0x18.
- Wrap: 40 entries written and drained in bursts of 8 with random rready -> rdata order preserved, rbin wraps past 31 to 0, rptr changes by exactly one bit per advance, no pop while rempty = 1.
- Back-to-back: rq2_wptr = Gray(4), rready = 1 -> rvalid high for 4 consecutive cycles, rd_en high each cycle, then rvalid = 0.
- Reset asserted while rvalid = 1 and rlevel = 3 -> outputs return to reset values asynchronously, before the next rclk edge.

Source files
------------

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty/almost-empty flags, occupancy count and FWFT output
// register for the dual-clock FIFO; everything lives in the rclk domain.
module rptr_empty_fwft #(
   parameter int ADDRSIZE = 4,
   parameter int DATASIZE = 32
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [DATASIZE-1:0] rmem_data,
   input  logic                rready,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                arempty,
   output logic                rvalid,
   output logic [DATASIZE-1:0] rdata,
   output logic [ADDRSIZE:0]   rlevel
);

   function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
      logic [ADDRSIZE:0] b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDRSIZE:0]   rbin_q, rbin_d;
   logic [ADDRSIZE:0]   rptr_q, rptr_d;
   logic [ADDRSIZE:0]   rlevel_q, rlevel_d;
   logic                rempty_q, rempty_d;
   logic                arempty_q, arempty_d;
   logic                rvalid_q, rvalid_d;
   logic [DATASIZE-1:0] rdata_q, rdata_d;
   logic                rd_en_s;
   logic [ADDRSIZE:0]   rgraynextp1_s;
   logic [ADDRSIZE:0]   wbin_s;

   // Pop only from a non-empty RAM into an empty or draining output register
   always_comb begin
      rd_en_s       = ~rempty_q & (~rvalid_q | rready);
      rbin_d        = rbin_q + {{ADDRSIZE{1'b0}}, rd_en_s};
      rptr_d        = bin2gray(rbin_d);
      rgraynextp1_s = bin2gray(rbin_d + {{ADDRSIZE{1'b0}}, 1'b1});
      wbin_s        = gray2bin(rq2_wptr);
      rempty_d      = (rptr_d == rq2_wptr);
      arempty_d     = rempty_d | (rgraynextp1_s == rq2_wptr);
      rlevel_d      = wbin_s - rbin_d;
      if (rd_en_s) begin
         rvalid_d = 1'b1;
         rdata_d  = rmem_data;
      end else if (rready & rvalid_q) begin
         rvalid_d = 1'b0;
         rdata_d  = rdata_q;
      end else begin
         rvalid_d = rvalid_q;
         rdata_d  = rdata_q;
      end
   end

   // State register; reset discards any unread output word
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q    <= {(ADDRSIZE+1){1'b0}};
         rptr_q    <= {(ADDRSIZE+1){1'b0}};
         rlevel_q  <= {(ADDRSIZE+1){1'b0}};
         rempty_q  <= 1'b1;
         arempty_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= {DATASIZE{1'b0}};
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rlevel_q  <= rlevel_d;
         rempty_q  <= rempty_d;
         arempty_q <= arempty_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign raddr   = rbin_q[ADDRSIZE-1:0];
   assign rptr    = rptr_q;
   assign rempty  = rempty_q;
   assign arempty = arempty_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: directed table, multi-cycle corner sequences and
// randomized traffic against a count-based FIFO model with a data scoreboard.
module tb_rptr_empty_fwft;

   logic        rclk;
   logic        rrst_n;
   logic [4:0]  rq2_wptr;
   logic [31:0] rmem_data;
   logic        rready;
   logic [3:0]  raddr;
   logic [4:0]  rptr;
   logic        rempty;
   logic        arempty;
   logic        rvalid;
   logic [31:0] rdata;
   logic [4:0]  rlevel;

   logic [31:0] mem [16];
   assign rmem_data = mem[raddr];

   rptr_empty_fwft #(.ADDRSIZE(4), .DATASIZE(32)) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rq2_wptr  (rq2_wptr),
      .rmem_data (rmem_data),
      .rready    (rready),
      .raddr     (raddr),
      .rptr      (rptr),
      .rempty    (rempty),
      .arempty   (arempty),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .rlevel    (rlevel)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int n_vec  = 0;
   int n_miss = 0;
   int n_xfer = 0;

   // Reference model: absolute write/read counts, output register, scoreboard
   int          m_w, m_r;
   logic        m_empty, m_arempty, m_valid;
   logic [31:0] m_data;
   logic [4:0]  m_level;
   logic [31:0] sb [$];

   typedef struct {
      int          w_cnt;
      logic [31:0] wdata;
      logic        rdy;
      logic        e, a, v;
      logic [4:0]  lvl, ptr;
      logic [31:0] d;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = 5'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [31:0] v);
      mem[m_w % 16] = v;
      sb.push_back(v);
      m_w++;
      rq2_wptr = gray(m_w);
   endtask

   task automatic step(input string tag);
      logic [4:0] prev_ptr;
      logic       prev_empty;
      int         occ;
      bit         pop;
      if (rvalid && rready) begin
         n_xfer++;
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s xfer: got %0h expected no valid word", tag, rdata);
         end else begin
            chk({tag, " xfer data"}, rdata, sb.pop_front());
         end
      end
      prev_ptr   = rptr;
      prev_empty = rempty;
      pop = !m_empty && (!m_valid || rready);
      if (pop) begin
         m_data  = mem[m_r % 16];
         m_valid = 1'b1;
         m_r++;
      end else if (rready && m_valid) begin
         m_valid = 1'b0;
      end
      occ       = m_w - m_r;
      m_empty   = (occ == 0);
      m_arempty = (occ <= 1);
      m_level   = 5'(occ);
      @(posedge rclk);
      #1;
      chk({tag, " rempty"},  32'(rempty),  32'(m_empty));
      chk({tag, " arempty"}, 32'(arempty), 32'(m_arempty));
      chk({tag, " rvalid"},  32'(rvalid),  32'(m_valid));
      chk({tag, " rdata"},   rdata,        m_data);
      chk({tag, " rlevel"},  32'(rlevel),  32'(m_level));
      chk({tag, " rptr"},    32'(rptr),    32'(gray(m_r)));
      chk({tag, " raddr"},   32'(raddr),   32'(m_r % 16));
      chk({tag, " rptr onebit"}, 32'($countones(rptr ^ prev_ptr) <= 1), 32'd1);
      if (prev_empty) chk({tag, " no pop when empty"}, 32'(rptr), 32'(prev_ptr));
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      #1;
      chk("rst rempty",  32'(rempty),  32'd1);
      chk("rst arempty", 32'(arempty), 32'd1);
      chk("rst rvalid",  32'(rvalid),  32'd0);
      chk("rst rptr",    32'(rptr),    32'd0);
      chk("rst rlevel",  32'(rlevel),  32'd0);
      chk("rst rdata",   rdata,        32'd0);
      chk("rst raddr",   32'(raddr),   32'd0);
      m_w = 0; m_r = 0;
      m_empty = 1'b1; m_arempty = 1'b1; m_valid = 1'b0;
      m_data = 32'd0; m_level = 5'd0;
      sb.delete();
      rq2_wptr = 5'd0;
      rready   = 1'b0;
      @(negedge rclk);
      rrst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, adv, x0, cyc;
      logic [4:0] pp;
      rrst_n   = 1'b1;
      rready   = 1'b0;
      rq2_wptr = 5'd0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      tbl[0] = '{0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
      tbl[1] = '{1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h0};
      tbl[2] = '{1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 32'hA5A5A5A5};
      tbl[3] = '{1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 32'hA5A5A5A5};
      tbl[4] = '{1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 32'hA5A5A5A5};
      tbl[5] = '{1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 32'hA5A5A5A5};
      tbl[6] = '{1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 32'hA5A5A5A5};
      tbl[7] = '{2, 32'h11,       1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1, 32'hA5A5A5A5};
      tbl[8] = '{2, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd3, 32'h11};
      #2;
      do_reset();

      // Idle with rready high must not move the pointer
      rready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step("idle");
         chk("idle raddr", 32'(raddr), 32'd0);
      end

      // Directed table: first word latency, hold, release, second word
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].w_cnt > m_w) wr(tbl[i].wdata);
         rready = tbl[i].rdy;
         step("tbl");
         chk("tbl rempty",  32'(rempty),  32'(tbl[i].e));
         chk("tbl arempty", 32'(arempty), 32'(tbl[i].a));
         chk("tbl rvalid",  32'(rvalid),  32'(tbl[i].v));
         chk("tbl rlevel",  32'(rlevel),  32'(tbl[i].lvl));
         chk("tbl rptr",    32'(rptr),    32'(tbl[i].ptr));
         chk("tbl rdata",   rdata,        tbl[i].d);
      end

      // Full RAM: 16 entries drained one per cycle
      do_reset();
      for (int i = 0; i < 16; i++) wr(32'(i));
      rready = 1'b1;
      step("full");
      chk("full rlevel16", 32'(rlevel), 32'd16);
      chk("full notempty", 32'(rempty), 32'd0);
      x0 = n_xfer;
      for (int i = 0; i < 17; i++) step("full");
      chk("full xfers", 32'(n_xfer - x0), 32'd16);
      chk("full rptr end", 32'(rptr), 32'h18);
      chk("full rempty end", 32'(rempty), 32'd1);

      // Back-to-back throughput
      do_reset();
      for (int i = 0; i < 4; i++) wr($urandom);
      rready = 1'b1;
      cnt = 0; adv = 0;
      for (int i = 0; i < 8; i++) begin
         pp = rptr;
         step("b2b");
         if (rvalid) cnt++;
         if (rptr != pp) adv++;
      end
      chk("b2b valid cycles", 32'(cnt), 32'd4);
      chk("b2b pops", 32'(adv), 32'd4);

      // Wrap: 40 entries in bursts of 8 with random rready
      do_reset();
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < 8; k++) begin
            wr($urandom);
            rready = 1'($urandom_range(0, 1));
            step("wrap");
         end
         cyc = 0;
         while ((m_w != m_r || m_valid) && cyc < 300) begin
            rready = 1'($urandom_range(0, 1));
            step("wrap");
            cyc++;
         end
         chk("wrap drain", 32'(sb.size()), 32'd0);
      end
      chk("wrap count", 32'(m_r), 32'd40);

      // Asynchronous reset while a word is held and 3 remain in RAM
      do_reset();
      for (int i = 0; i < 4; i++) wr($urandom);
      rready = 1'b0;
      step("prerst");
      step("prerst");
      chk("prerst rvalid", 32'(rvalid), 32'd1);
      chk("prerst rlevel", 32'(rlevel), 32'd3);
      do_reset();
      rready = 1'b1;
      step("postrst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
